dmem_stall_responder: RTL

- Multi-cycle data-memory responder on the MEM-stage side of the pipelined CPU.
- Answers the pipeline's load/store requests (memread/memwrite, address, write data) after a programmable latency.
- Asserts a stall back to the pipeline while an access is in flight, so PC, IF/ID, ID/EX, EX/MEM and MEM/WB hold.
- Replaces the zero-latency data memory. Storage is an internal word array.

---
 rtl/dmem_stall_responder.sv | 106 ++++++++++
 1 files changed

// File: rtl/dmem_stall_responder.sv
// Multi-cycle data-memory responder for the MEM stage: stalls the pipeline while an access
// is in flight, then returns load data with a one-cycle ack (and err for rejected requests).
module dmem_stall_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 3,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [31:0] memaddr_i,
  input  logic [31:0] writedata_i,
  output logic [31:0] memdata_o,
  output logic        stall_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IdxW-1:0]   r_idx;
  logic [31:0]       r_wdata;
  logic              r_write;
  logic [31:0]       r_memdata;
  logic              r_ack;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic w_req;
  logic w_bad;
  logic w_access;
  logic w_mem_we;

  assign w_req    = memread_i | memwrite_i;
  assign w_bad    = (memaddr_i[1:0] != 2'b00)
                  | ({2'b00, memaddr_i[31:2]} >= DEPTH_WORDS)
                  | (memread_i & memwrite_i);
  assign w_access = (r_state == StBusy) && (r_cnt == '0);
  // A reset coinciding with the access edge abandons the pending write.
  assign w_mem_we = w_access & r_write & ~rst_i;

  assign stall_o   = (r_state == StBusy) | ((r_state == StIdle) & w_req);
  assign ack_o     = r_ack;
  assign err_o     = r_err;
  assign memdata_o = r_memdata;

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_memdata <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_req && !w_bad) begin
            r_idx   <= memaddr_i[IdxW+1:2];
            r_wdata <= writedata_i;
            r_write <= memwrite_i;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_state <= StBusy;
          end else if (w_req) begin
            r_memdata <= '0;
            r_ack     <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= StDone;
          end
        end
        StBusy: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_memdata <= r_write ? 32'h0 : r_mem[r_idx];
            r_ack     <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule
